// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit and its queue.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Bits needed to hold any value from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous instruction queue: push, pop, clear, occupancy count and head entry
// read straight out of the storage flops.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4,
    parameter int  CW      = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  entry_t        push_data,
    output entry_t        head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   wr_d;
    logic [PW-1:0]   rd_q;
    logic [PW-1:0]   rd_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            do_push;
    logic            do_pop;

    // Pointer and occupancy next state; a full queue still accepts a push when it pops.
    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (clear) begin
            do_push = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
        end else begin
            if (do_push) begin
                wr_d = wr_q + PW'(1);
            end else begin
                wr_d = wr_q;
            end
            if (do_pop) begin
                rd_d = rd_q + PW'(1);
            end else begin
                rd_d = rd_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= push_data;
            end
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential address generation, in-flight request tracking
// with stale-response discard after redirect, and an instruction queue towards decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            proc_req,
    output logic [XLEN-1:0] addr,
    input  logic            mem_ready,
    input  logic            valid,
    input  logic [XLEN-1:0] rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    localparam int OW = cnt_width(MAX_OUT);
    localparam int QW = cnt_width(DEPTH);
    localparam int SW = ((OW > QW) ? OW : QW) + 1;

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q;
    logic [XLEN-1:0] resp_pc_d;
    logic [OW-1:0]   live_q;
    logic [OW-1:0]   live_d;
    logic [OW-1:0]   stale_q;
    logic [OW-1:0]   stale_d;
    logic [QW-1:0]   q_count;
    entry_t          q_head;
    entry_t          q_din;
    logic [SW-1:0]   out_sum;
    logic [SW-1:0]   credit_sum;
    logic [XLEN-1:0] redir_base;
    logic            accept;
    logic            resp_drop;
    logic            resp_push;
    logic            q_pop;
    logic            unused_pc_bits;

    // Live requests reserve a queue slot up front, so a live response always has room.
    assign out_sum    = SW'(live_q) + SW'(stale_q);
    assign credit_sum = SW'(live_q) + SW'(q_count);
    assign proc_req   = !reset && !redirect && (out_sum < SW'(MAX_OUT)) && (credit_sum < SW'(DEPTH));
    assign addr       = fetch_pc_q;
    assign accept     = proc_req && mem_ready;

    assign resp_drop  = valid && (stale_q != '0);
    assign resp_push  = valid && (stale_q == '0) && (live_q != '0) && !redirect;
    assign redir_base = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    assign instr_valid = (q_count != '0);
    assign q_pop       = instr_valid && instr_ready && !redirect;
    assign q_din       = '{pc: resp_pc_q, instr: rdata};

    // PC and in-flight counter next state; a redirect turns every live request stale.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        live_d     = live_q;
        stale_d    = stale_q;
        if (redirect) begin
            fetch_pc_d = redir_base;
            resp_pc_d  = redir_base;
            live_d     = '0;
            stale_d    = stale_q + live_q - OW'(valid && (out_sum != '0));
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (resp_push) begin
                resp_pc_d = resp_pc_q + XLEN'(INSTR_BYTES);
            end else begin
                resp_pc_d = resp_pc_q;
            end
            live_d  = live_q + OW'(accept) - OW'(resp_push);
            stale_d = stale_q - OW'(resp_drop);
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            live_q     <= '0;
            stale_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            live_q     <= live_d;
            stale_q    <= stale_d;
        end
    end

    fetch_queue #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH),
        .CW      (QW)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (resp_push),
        .pop       (q_pop),
        .clear     (redirect),
        .push_data (q_din),
        .head      (q_head),
        .count     (q_count)
    );

    assign instr    = q_head.instr;
    assign instr_pc = q_head.pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch unit sitting between the PC/branch logic and the instruction memory port, ahead of decode. It generates sequential fetch addresses itself, keeps up to MAX_OUT memory requests in flight, buffers returned words with their PCs in a DEPTH-entry queue, and hands them to decode with a valid/ready handshake. On a redirect it flushes the queue and silently discards the responses to requests that were already in flight.

## Interface
- XLEN, 32: address and instruction width.
- DEPTH, 4: instruction queue entries; power of two, ≥2.
- MAX_OUT, 2: maximum accepted-but-unanswered memory requests, including stale ones; ≥1.
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] are zero.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- redirect  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] are ignored and treated as 0.
- proc_req  out  1  memory request valid.
- addr  out  XLEN  request address; word aligned.
- mem_ready  in  1  memory accepts the request this cycle.
- valid  in  1  memory response valid, one cycle per response.
- rdata  in  XLEN  response word.
- instr_valid  out  1  queue head valid.
- instr  out  XLEN  queue head instruction word.
- instr_pc  out  XLEN  PC of the queue head.
- instr_ready  in  1  decode consumes the head this cycle.

## Operation
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next live response.
  - live_cnt: live in-flight requests.
  - stale_cnt: discarded in-flight requests.
  - Queue count.
- Accept: a request is accepted when proc_req && mem_ready. On accept, fetch_pc += 4 (wraps modulo 2^XLEN) and live_cnt increments.
- proc_req = !redirect && (live_cnt + stale_cnt < MAX_OUT) && (live_cnt + count < DEPTH). The credit rule guarantees that every live response has a free queue slot. addr = fetch_pc at all times.
- Address stability: addr is stable while proc_req is high and the request is not accepted. proc_req may drop only in a redirect cycle (request abandoned). The memory tolerates an abandoned request.
- Response with stale_cnt > 0: stale_cnt decrements and the word is dropped.
- Response with stale_cnt == 0 and live_cnt > 0: push {resp_pc, rdata}, resp_pc += 4, live_cnt decrements.
- Response with live_cnt + stale_cnt == 0: the response is ignored.
- Pop: when instr_valid && instr_ready. instr_valid = (count != 0). instr and instr_pc come from the head entry.
- Push and pop in the same cycle are both allowed, including when the queue is full or empty (count unchanged).
- Redirect cycle:
  - Queue cleared.
  - fetch_pc and resp_pc are loaded with {redirect_pc[XLEN-1:2], 2'b00}.
  - stale_cnt ← stale_cnt + live_cnt − (valid ? 1 : 0), where the responder is counted as stale first.
  - live_cnt ← 0.
  - Any response arriving in the redirect cycle is dropped.
  - A pop in the redirect cycle has no effect beyond the clear.
- Back-to-back redirects are allowed; the last one wins.

## Timing
- Reset values:
  - proc_req 0, addr RESET_PC, instr_valid 0.
  - instr and instr_pc are 0.
  - All counters 0; fetch_pc and resp_pc are RESET_PC.
  - The memory is reset at the same time; no stale responses are expected after reset.
- Reset asserted mid-operation has the same effect as reset from power-up: in-flight and queued state are lost.
- First cycle after reset deasserts: proc_req = 1, addr = RESET_PC.
- Response latency: a response at edge N appears at the queue head (instr_valid = 1) after edge N+1 when the queue was empty. No combinational path from valid or rdata to instr.
- Combinational paths from redirect: redirect → proc_req only. No combinational path from instr_ready to proc_req.
- Throughput: one instruction per cycle sustained when memory answers within MAX_OUT cycles and decode is always ready.

## Structure
- Package fetch_pkg:
  - INSTR_BYTES = 4.
  - Typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;} (XLEN as package parameter default 32).
  - Counter width helper for MAX_OUT and DEPTH.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, DEPTH entries, with push, pop, clear, count, and registered head output. Pointers wrap modulo DEPTH.
- fetch_unit holds the PC registers, live and stale counters, and the request gating.

## Test plan
- Reset, then mem_ready = 1 with responses one cycle after accept, instr_ready = 1 → addr sequence 0x0, 0x4, 0x8…; instr_pc follows the same sequence with instr == rdata; instr_valid is continuous after the first response.
- instr_ready = 0 with DEPTH = 4 and MAX_OUT = 2 → at most 4 accepts in total; proc_req falls to 0 with count + live_cnt = 4. Raising instr_ready then drains 4 entries in order, and fetch resumes at 0x10.
- mem_ready = 0 for 5 cycles → proc_req stays 1 and addr stays 0x0 throughout; the request is accepted on the 6th cycle.
- Two requests outstanding (0x8, 0xC), redirect to 0x100 → queue empties next cycle; the two following responses are dropped; the next queued instr_pc is 0x100.
- Redirect in the same cycle as a response, with 2 in flight → stale_cnt = 1, the responding word is dropped, and one more drop follows. redirect_pc = 0x103 → addr = 0x100.
- Response with nothing in flight → ignored: no push, counters unchanged. Fetch near the top of the address space → fetch_pc wraps from 0xFFFF_FFFC to 0x0.
